// File: rtl/lcd_pkg.sv
// lcd_pkg: definitions shared by the LCD read path (lcd_reader) and the LCD write driver.
//   - lcd_state_e : read FSM state encoding
//   - LCD bus bit positions (busy flag in bit 7, address counter in bits 6:0)
//   - default HD44780-style timing in clock cycles
//   - lcd_cnt_width() : width of a phase down-counter able to hold the longest phase
package lcd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StEnHigh,
    StHold,
    StDone
  } lcd_state_e;

  // Status-read byte layout
  localparam int unsigned LcdBfBit   = 7;
  localparam int unsigned LcdAddrMsb = 6;
  localparam int unsigned LcdAddrW   = 7;

  // Default bus timing in clock cycles
  localparam int unsigned LcdDefSetupCyc = 2;
  localparam int unsigned LcdDefPulseCyc = 25;
  localparam int unsigned LcdDefHoldCyc  = 2;
  localparam int unsigned LcdDefPollMax  = 65535;

  // A phase of N cycles loads N-1, so the counter must hold max(N)-1.
  function automatic int unsigned lcd_cnt_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return ($clog2(m) > 0) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/lcd_reader_if.sv
// lcd_reader_if: request/response and LCD bus signals of the LCD read engine.
//   master : host side (drives start/rs_sel, models the panel's db_in)
//   slave  : lcd_reader side (drives rw/rs/enable and the read results)
interface lcd_reader_if;
  logic       start;
  logic       rs_sel;
  logic [7:0] db_in;
  logic       rw;
  logic       rs;
  logic       enable;
  logic       busy;
  logic       valid;
  logic [7:0] rdata;
  logic       busy_flag;
  logic [6:0] addr;
  logic       timeout;

  modport master (
    output start, rs_sel, db_in,
    input  rw, rs, enable, busy, valid, rdata, busy_flag, addr, timeout
  );

  modport slave (
    input  start, rs_sel, db_in,
    output rw, rs, enable, busy, valid, rdata, busy_flag, addr, timeout
  );
endinterface

// File: rtl/lcd_strobe_timer.sv
// lcd_strobe_timer: loadable down-counter timing one bus phase.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load       : load i_load_val (phase length minus one)
//   i_load_val   : value to load
//   o_done       : counter is zero, i.e. current cycle is the last of the phase
module lcd_strobe_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/lcd_reader.sv
// lcd_reader: performs one HD44780-style read cycle (SETUP -> E pulse -> HOLD) per request and
// reports the byte sampled on the last E-high cycle, split into busy flag / address for
// status reads.
//   i_clk, i_rst : clock, synchronous active-high reset
//   io_bus       : lcd_reader_if.slave (start/rs_sel/db_in in; rw/rs/enable, busy, valid,
//                  rdata/busy_flag/addr/timeout out)
// Optional feature macro LCD_READER_POLL_EN: a status read (rs_sel=0) repeats until the busy
// flag reads 0 or POLL_MAX reads were made (timeout=1). Without it timeout is tied 0.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC = LcdDefSetupCyc,
  parameter int unsigned PULSE_CYC = LcdDefPulseCyc,
  parameter int unsigned HOLD_CYC  = LcdDefHoldCyc,
  parameter int unsigned POLL_MAX  = LcdDefPollMax
) (
  input logic         i_clk,
  input logic         i_rst,
  lcd_reader_if.slave io_bus
);

  if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1 || POLL_MAX < 1) begin : g_param_check
    $error("lcd_reader: SETUP_CYC, PULSE_CYC, HOLD_CYC and POLL_MAX must all be >= 1");
  end

  localparam int unsigned CntW = lcd_cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] PulseLd = CntW'(PULSE_CYC - 1);
  localparam logic [CntW-1:0] HoldLd  = CntW'(HOLD_CYC - 1);

  lcd_state_e r_state, w_state_d;

  logic            r_rs;
  logic [7:0]      r_sample;
  logic [7:0]      r_rdata;
  logic            r_busy_flag;
  logic [6:0]      r_addr;

  logic            w_load;
  logic [CntW-1:0] w_load_val;
  logic            w_timer_done;
  logic            w_capture;
  logic            w_commit;
  logic            w_poll_again;
  logic            w_in_txn;

  lcd_strobe_timer #(
    .CNT_W (CntW)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_timer_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next state, timer control and bus outputs
  always_comb begin
    w_state_d  = r_state;
    w_load     = 1'b0;
    w_load_val = SetupLd;
    w_capture  = 1'b0;
    w_commit   = 1'b0;
    w_in_txn   = 1'b0;

    io_bus.rw     = 1'b0;
    io_bus.rs     = 1'b0;
    io_bus.enable = 1'b0;
    io_bus.busy   = 1'b1;
    io_bus.valid  = 1'b0;

    unique case (r_state)
      StIdle: begin
        io_bus.busy = 1'b0;
        if (io_bus.start) begin
          w_state_d  = StSetup;
          w_load     = 1'b1;
          w_load_val = SetupLd;
        end
      end
      StSetup: begin
        w_in_txn = 1'b1;
        if (w_timer_done) begin
          w_state_d  = StEnHigh;
          w_load     = 1'b1;
          w_load_val = PulseLd;
        end
      end
      StEnHigh: begin
        w_in_txn      = 1'b1;
        io_bus.enable = 1'b1;
        if (w_timer_done) begin
          w_state_d  = StHold;
          w_load     = 1'b1;
          w_load_val = HoldLd;
          w_capture  = 1'b1;
        end
      end
      StHold: begin
        w_in_txn = 1'b1;
        if (w_timer_done) begin
          if (w_poll_again) begin
            w_state_d  = StSetup;
            w_load     = 1'b1;
            w_load_val = SetupLd;
          end else begin
            w_state_d = StDone;
            w_commit  = 1'b1;
          end
        end
      end
      StDone: begin
        io_bus.valid = 1'b1;
        w_state_d    = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    io_bus.rw = w_in_txn;
    io_bus.rs = w_in_txn & r_rs;
  end

  // Request capture, bus sample and result registers. Results only change on entry to DONE so
  // intermediate poll reads are never visible.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rs        <= 1'b0;
      r_sample    <= '0;
      r_rdata     <= '0;
      r_busy_flag <= 1'b0;
      r_addr      <= '0;
    end else begin
      if (r_state == StIdle && io_bus.start) begin
        r_rs <= io_bus.rs_sel;
      end
      if (w_capture) begin
        r_sample <= io_bus.db_in;
      end
      if (w_commit) begin
        r_rdata     <= r_sample;
        r_busy_flag <= ~r_rs & r_sample[LcdBfBit];
        r_addr      <= r_rs ? '0 : r_sample[LcdAddrMsb:0];
      end
    end
  end

  assign io_bus.rdata     = r_rdata;
  assign io_bus.busy_flag = r_busy_flag;
  assign io_bus.addr      = r_addr;

`ifdef LCD_READER_POLL_EN
  localparam int unsigned PollW = $clog2(POLL_MAX + 1);
  localparam logic [PollW-1:0] PollLast = PollW'(POLL_MAX - 1);

  // Reads completed before the one currently in HOLD
  logic [PollW-1:0] r_reads;
  logic             r_timeout;

  assign w_poll_again = ~r_rs & r_sample[LcdBfBit] & (r_reads != PollLast);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_reads   <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == StIdle) begin
        r_reads <= '0;
      end else if (r_state == StHold && w_timer_done) begin
        r_reads <= r_reads + 1'b1;
      end
      // Reaching DONE with BF still set on a status read means the poll budget ran out
      if (w_commit) begin
        r_timeout <= ~r_rs & r_sample[LcdBfBit];
      end
    end
  end

  assign io_bus.timeout = r_timeout;
`else
  assign w_poll_again   = 1'b0;
  assign io_bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_reader.sv
// tb_lcd_reader: self-checking bench for lcd_reader (SETUP_CYC=2, PULSE_CYC=25, HOLD_CYC=2).
// Cycle n is the clock period following edge n-1; a start sampled at edge 0 begins cycle 1.
module tb_lcd_reader;

  localparam int unsigned S = 2;
  localparam int unsigned P = 25;
  localparam int unsigned H = 2;
  localparam int unsigned T = S + P + H;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  lcd_reader_if bus ();

  lcd_reader #(
    .SETUP_CYC (S),
    .PULSE_CYC (P),
    .HOLD_CYC  (H),
    .POLL_MAX  (65535)
  ) u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

`ifdef LCD_READER_POLL_EN
  lcd_reader_if bus3 ();

  lcd_reader #(
    .SETUP_CYC (S),
    .PULSE_CYC (P),
    .HOLD_CYC  (H),
    .POLL_MAX  (3)
  ) u_dut3 (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus3)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] ctl();
    return {bus.rw, bus.rs, bus.enable, bus.busy, bus.valid};
  endfunction

  function automatic logic [16:0] dat();
    return {bus.rdata, bus.busy_flag, bus.addr, bus.timeout};
  endfunction

  task automatic test_reset();
    bus.start  = 1'b0;
    bus.rs_sel = 1'b0;
    bus.db_in  = 8'hFF;
`ifdef LCD_READER_POLL_EN
    bus3.start  = 1'b0;
    bus3.rs_sel = 1'b0;
    bus3.db_in  = 8'hFF;
`endif
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if (ctl() !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 00000", ctl());
    end
    n_tests++;
    if (dat() !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", dat());
    end
    rst = 1'b0;
    step();
    n_tests++;
    if (ctl() !== 5'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b want 00000", ctl());
    end
  endtask

  task automatic test_bf_read();
    int en_first, en_last, v_cyc, n_valid;
    en_first = -1;
    en_last  = -1;
    v_cyc    = -1;
    n_valid  = 0;
    bus.rs_sel = 1'b0;
    bus.db_in  = 8'h8A;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.enable === 1'b1) begin
        if (en_first < 0) en_first = c;
        en_last = c;
      end
      if (bus.valid === 1'b1) begin
        n_valid++;
        v_cyc = c;
      end
      step();
    end
    n_tests++;
    if (en_first != 3 || en_last != 27) begin
      n_fail++;
      $display("FAIL bf_enable_window: got %0d..%0d want 3..27", en_first, en_last);
    end
    n_tests++;
    if (v_cyc != 30 || n_valid != 1) begin
      n_fail++;
      $display("FAIL bf_valid: got cycle %0d count %0d want cycle 30 count 1", v_cyc, n_valid);
    end
    n_tests++;
    if (dat() !== {8'h8A, 1'b1, 7'h0A, 1'b0}) begin
      n_fail++;
      $display("FAIL bf_data: got %h want %h", dat(), {8'h8A, 1'b1, 7'h0A, 1'b0});
    end
  endtask

  task automatic test_data_read();
    int rs_bad, v_cyc;
    rs_bad = 0;
    v_cyc  = -1;
    bus.rs_sel = 1'b1;
    bus.db_in  = 8'h41;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    bus.rs_sel = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      if (c <= 29 && (bus.rs !== 1'b1 || bus.rw !== 1'b1)) rs_bad++;
      if (bus.valid === 1'b1) v_cyc = c;
      step();
    end
    n_tests++;
    if (rs_bad != 0) begin
      n_fail++;
      $display("FAIL data_rs_rw: got %0d bad cycles want 0", rs_bad);
    end
    n_tests++;
    if (v_cyc != 30) begin
      n_fail++;
      $display("FAIL data_valid_cycle: got %0d want 30", v_cyc);
    end
    n_tests++;
    if (dat() !== {8'h41, 1'b0, 7'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL data_result: got %h want %h", dat(), {8'h41, 1'b0, 7'h00, 1'b0});
    end
  endtask

  task automatic test_ignored_start();
    int n_valid, v_cyc;
    logic busy31;
    n_valid = 0;
    v_cyc   = -1;
    busy31  = 1'bx;
    bus.rs_sel = 1'b1;
    bus.db_in  = 8'hC3;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    bus.rs_sel = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      if (bus.valid === 1'b1) begin
        n_valid++;
        v_cyc = c;
      end
      if (c == 31) busy31 = bus.busy;
      bus.start = (c == 5 || c == 30);
      step();
    end
    bus.start = 1'b0;
    n_tests++;
    if (n_valid != 1 || v_cyc != 30) begin
      n_fail++;
      $display("FAIL ignored_start_valid: got count %0d cycle %0d want 1 at 30", n_valid, v_cyc);
    end
    n_tests++;
    if (busy31 !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_start_busy: got %b want 0 in cycle 31", busy31);
    end
    n_tests++;
    if (dat() !== {8'hC3, 1'b0, 7'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL ignored_start_data: got %h want %h", dat(), {8'hC3, 1'b0, 7'h00, 1'b0});
    end
  endtask

  task automatic test_mid_reset();
    int n_valid, n_en;
    n_valid = 0;
    n_en    = 0;
    bus.rs_sel = 1'b1;
    bus.db_in  = 8'h5A;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c < 15; c++) step();
    n_tests++;
    if (bus.enable !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_pre_enable: got %b want 1 in cycle 15", bus.enable);
    end
    rst = 1'b1;
    step();
    n_tests++;
    if (ctl() !== 5'b0 || dat() !== 17'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got ctl %b data %h want all 0", ctl(), dat());
    end
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.valid === 1'b1) n_valid++;
      if (bus.enable === 1'b1) n_en++;
      step();
    end
    n_tests++;
    if (n_valid != 0 || n_en != 0) begin
      n_fail++;
      $display("FAIL mid_reset_abort: got valid %0d enable %0d want 0 0", n_valid, n_en);
    end
  endtask

  // Random reads with a spurious start mid-transaction, rs_sel toggling after capture and db_in
  // only carrying the real byte on the last E-high cycle.
  task automatic test_random();
    logic [16:0] prev;
    prev = 17'h0;
    for (int t = 0; t < 16; t++) begin
      logic       rs;
      logic [7:0] db;
      int         spur;
      int         gap;
      rs   = 1'($urandom);
      db   = 8'($urandom);
`ifdef LCD_READER_POLL_EN
      if (!rs) db[7] = 1'b0;
`endif
      spur = int'($urandom_range(T + 1, 1));
      gap  = int'($urandom_range(3, 0));
      for (int g = 0; g < gap; g++) begin
        n_tests++;
        if (ctl() !== 5'b0) begin
          n_fail++;
          $display("FAIL rand_idle t%0d: got %b want 00000", t, ctl());
        end
        step();
      end
      bus.rs_sel = rs;
      bus.db_in  = 8'($urandom);
      bus.start  = 1'b1;
      step();
      for (int c = 1; c <= int'(T) + 2; c++) begin
        int          o;
        logic        in_txn;
        logic [4:0]  exp_ctl;
        logic [16:0] exp_d;
        in_txn  = (c <= int'(T));
        o       = (c - 1) % int'(T);
        exp_ctl = {in_txn, in_txn & rs, in_txn && o >= int'(S) && o < int'(S + P),
                   c <= int'(T) + 1, c == int'(T) + 1};
        n_tests++;
        if (ctl() !== exp_ctl) begin
          n_fail++;
          $display("FAIL rand_ctl t%0d c%0d: got %b want %b", t, c, ctl(), exp_ctl);
        end
        if (c == 1) begin
          n_tests++;
          if (dat() !== prev) begin
            n_fail++;
            $display("FAIL rand_hold t%0d: got %h want %h", t, dat(), prev);
          end
        end
        if (c == int'(T) + 1) begin
          exp_d = {db, ~rs & db[7], rs ? 7'h00 : db[6:0], 1'b0};
          n_tests++;
          if (dat() !== exp_d) begin
            n_fail++;
            $display("FAIL rand_data t%0d: got %h want %h", t, dat(), exp_d);
          end
          prev = exp_d;
        end
        bus.start  = (c == spur);
        bus.rs_sel = 1'($urandom);
        bus.db_in  = (in_txn && o == int'(S + P) - 1) ? db : 8'($urandom);
        step();
      end
      bus.start = 1'b0;
    end
  endtask

`ifdef LCD_READER_POLL_EN
  task automatic test_poll_release();
    int n_valid, v_cyc, n_en;
    n_valid = 0;
    v_cyc   = -1;
    n_en    = 0;
    bus.rs_sel = 1'b0;
    bus.db_in  = 8'hFF;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 4 * int'(T) + 6; c++) begin
      int k, o;
      k = (c - 1) / int'(T);
      o = (c - 1) % int'(T);
      if (bus.valid === 1'b1) begin
        n_valid++;
        v_cyc = c;
      end
      if (bus.enable === 1'b1) n_en++;
      if (o == int'(S + P) - 1) bus.db_in = (k < 3) ? (8'h80 | 8'($urandom)) : 8'h05;
      else bus.db_in = 8'($urandom);
      step();
    end
    n_tests++;
    if (n_valid != 1 || v_cyc != 117) begin
      n_fail++;
      $display("FAIL poll_release_valid: got count %0d cycle %0d want 1 at 117", n_valid, v_cyc);
    end
    n_tests++;
    if (n_en != 4 * int'(P)) begin
      n_fail++;
      $display("FAIL poll_release_reads: got %0d enable cycles want %0d", n_en, 4 * P);
    end
    n_tests++;
    if (dat() !== {8'h05, 1'b0, 7'h05, 1'b0}) begin
      n_fail++;
      $display("FAIL poll_release_data: got %h want %h", dat(), {8'h05, 1'b0, 7'h05, 1'b0});
    end
  endtask

  task automatic test_poll_timeout();
    int n_valid, v_cyc;
    n_valid = 0;
    v_cyc   = -1;
    bus3.rs_sel = 1'b0;
    bus3.db_in  = 8'hFF;
    bus3.start  = 1'b1;
    step();
    bus3.start = 1'b0;
    for (int c = 1; c <= 3 * int'(T) + 10; c++) begin
      if (bus3.valid === 1'b1) begin
        n_valid++;
        v_cyc = c;
      end
      step();
    end
    n_tests++;
    if (n_valid != 1 || v_cyc != 88) begin
      n_fail++;
      $display("FAIL poll_timeout_valid: got count %0d cycle %0d want 1 at 88", n_valid, v_cyc);
    end
    n_tests++;
    if ({bus3.rdata, bus3.busy_flag, bus3.addr, bus3.timeout} !== {8'hFF, 1'b1, 7'h7F, 1'b1}) begin
      n_fail++;
      $display("FAIL poll_timeout_data: got %h want %h",
               {bus3.rdata, bus3.busy_flag, bus3.addr, bus3.timeout},
               {8'hFF, 1'b1, 7'h7F, 1'b1});
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    test_reset();
`ifndef LCD_READER_POLL_EN
    test_bf_read();
`endif
    test_data_read();
    test_ignored_start();
    test_mid_reset();
    test_random();
`ifdef LCD_READER_POLL_EN
    test_poll_release();
    test_poll_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_reader.md
LCD_READER -- requirements
Module: lcd_reader

Interface
REQ-001 SETUP_CYC, default 2: clocks rs/rw stable before enable rises (min 1).
REQ-002 PULSE_CYC, default 25: clocks enable held high; db_in sampled on its last cycle (min 1).
REQ-003 HOLD_CYC, default 2: clocks rs/rw held after enable falls (min 1).
REQ-004 POLL_MAX, default 65535: maximum busy-flag reads per poll request (used only with LCD_READER_POLL_EN).
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  request one read; accepted only in IDLE.
REQ-008 rs_sel  in  1  0 = busy-flag/address read, 1 = data-RAM read; captured with start.
REQ-009 db_in  in  8  LCD data bus as driven by the panel.
REQ-010 rw  out  1  1 during a read transaction, else 0.
REQ-011 rs  out  1  register select, holds captured rs_sel during a transaction.
REQ-012 enable  out  1  LCD E strobe.
REQ-013 busy  out  1  high from accepted start until valid cycle inclusive.
REQ-014 valid  out  1  one-cycle pulse; rdata/busy_flag/addr/timeout valid.
REQ-015 rdata  out  8  captured db_in.
REQ-016 busy_flag  out  1  rdata[7] when rs_sel=0, else 0.
REQ-017 addr  out  7  rdata[6:0] when rs_sel=0, else 0.
REQ-018 timeout  out  1  poll ended without BF=0; constant 0 without LCD_READER_POLL_EN.

Function
REQ-019 FSM states IDLE, SETUP, EN_HIGH, HOLD, DONE; one cycle counter shared by SETUP/EN_HIGH/HOLD.
REQ-020 IDLE: rw=0, enable=0; start=1 latches rs_sel and moves to SETUP next edge.
REQ-021 SETUP: rw=1, rs=latched value, enable=0 for SETUP_CYC cycles, then EN_HIGH.
REQ-022 EN_HIGH: enable=1 for PULSE_CYC cycles; db_in registered into rdata on the edge leaving EN_HIGH.
REQ-023 HOLD: enable=0, rw=1, rs held for HOLD_CYC cycles, then DONE.
REQ-024 DONE: valid=1 for exactly one cycle, rw=0, then IDLE; start in DONE ignored.
REQ-025 Latency: start sampled at edge 0 -> valid high in cycle SETUP_CYC+PULSE_CYC+HOLD_CYC+1.
REQ-026 start while busy=1 ignored; no queueing.
REQ-027 rdata/busy_flag/addr/timeout hold last values until the next DONE.
REQ-028 enable never high while rw=0; rs/rw never change while enable=1.

Reset
REQ-029 rst=1 at any edge forces IDLE; rw, rs, enable, busy, valid, rdata, busy_flag, addr, timeout = 0 after that edge.
REQ-030 Reset mid-transaction aborts it: no valid issued; enable falls on the reset edge.

Configuration
REQ-031 Macro LCD_READER_POLL_EN.
REQ-032 Defined: rs_sel=0 request repeats SETUP..HOLD while sampled bit7=1, up to POLL_MAX reads; DONE on first bit7=0 (timeout=0) or after POLL_MAX reads (timeout=1); only final read reported.
REQ-033 Undefined: every request is a single read; timeout tied 0; poll counter absent.

Structure
REQ-034 Shared package lcd_pkg: FSM state enum, LCD bit-position constants (BF bit 7, addr bits 6:0), default timing constants shared with the write driver.
REQ-035 Sub-module lcd_strobe_timer (loadable down-counter with done flag) used for all three phases; no other sub-modules.

Verification (SETUP_CYC=2, PULSE_CYC=25, HOLD_CYC=2)
REQ-036 start, rs_sel=0, db_in=8'h8A -> enable high cycles 3..27, valid in cycle 30, busy_flag=1, addr=7'h0A, rdata=8'h8A.
REQ-037 start, rs_sel=1, db_in=8'h41 -> rs=1 throughout, valid cycle 30, rdata=8'h41, busy_flag=0, addr=0.
REQ-038 start pulses in cycles 5 and 30 during transaction -> ignored; exactly one valid.
REQ-039 rst asserted cycle 15 (EN_HIGH) -> cycle 16 all outputs 0, FSM IDLE, no valid later.
REQ-040 POLL_EN, db_in bit7=1 for first 3 reads then 8'h05 -> single valid in cycle 117, addr=7'h05, timeout=0.
REQ-041 POLL_EN, POLL_MAX=3, db_in=8'hFF constant -> valid after 3 reads (cycle 88), busy_flag=1, timeout=1.
